// File: rtl/systolic_pkg.sv
// Shared defaults and state encoding for the systolic array edge logic.
package systolic_pkg;

  localparam int IFMAP_WIDTH_DEF  = 16;
  localparam int ARRAY_HEIGHT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } skew_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// One ifmap lane: DEPTH {data, valid} stages advancing on en; DEPTH=0 is a gated wire.
module skew_delay_line #(
  parameter int unsigned DEPTH = 0,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             stage_busy_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign valid_o      = en & valid_i;
    assign data_o       = valid_o ? data_i : '0;
    assign stage_busy_o = 1'b0;
  end else begin : g_chain
    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0][WIDTH-1:0] data_q;

    // Bubbles store zero data so a held stage never carries stale values.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= '0;
        data_q  <= '0;
      end else if (en) begin
        valid_q[0] <= valid_i;
        data_q[0]  <= valid_i ? data_i : '0;
        for (int k = 1; k < int'(DEPTH); k++) begin
          valid_q[k] <= valid_q[k-1];
          data_q[k]  <= data_q[k-1];
        end
      end
    end

    assign valid_o      = en & valid_q[DEPTH-1];
    assign data_o       = valid_o ? data_q[DEPTH-1] : '0;
    assign stage_busy_o = |valid_q;
  end

endmodule

// File: rtl/ifmap_in_skew_fifo.sv
// Skews an aligned ifmap vector onto a diagonal wavefront (lane i delayed i cycles)
// and reports when the last skewed element has left the array's left edge.
//
// state  | meaning
// IDLE   | no stream in flight
// STREAM | valid vectors arriving
// DRAIN  | input stopped, counting until lane ARRAY_HEIGHT-1 empties
module ifmap_in_skew_fifo
  import systolic_pkg::*;
#(
  parameter int IFMAP_WIDTH  = IFMAP_WIDTH_DEF,
  parameter int ARRAY_HEIGHT = ARRAY_HEIGHT_DEF
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    en,
  input  logic                                    valid_in,
  input  logic [ARRAY_HEIGHT-1:0][IFMAP_WIDTH-1:0] d_in_r,
  output logic [ARRAY_HEIGHT-1:0][IFMAP_WIDTH-1:0] d_out_w,
  output logic [ARRAY_HEIGHT-1:0]                 valid_out_w,
  output logic                                    busy,
  output logic                                    drain_done
);

  localparam int CNT_W = $clog2(ARRAY_HEIGHT) + 1;

  logic [ARRAY_HEIGHT-1:0] lane_busy;
  skew_state_e             state_q, state_d;
  logic [CNT_W-1:0]        drain_cnt_q, drain_cnt_d;

  for (genvar i = 0; i < ARRAY_HEIGHT; i++) begin : g_lane
    skew_delay_line #(
      .DEPTH(i),
      .WIDTH(IFMAP_WIDTH)
    ) u_lane (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .valid_i      (valid_in),
      .data_i       (d_in_r[i]),
      .data_o       (d_out_w[i]),
      .valid_o      (valid_out_w[i]),
      .stage_busy_o (lane_busy[i])
    );
  end

  assign busy = valid_in | (|lane_busy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
    end else if (en) begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // The STREAM->DRAIN cycle is the first drain slot; the pulse fires in the cycle
  // the counter steps to zero, which is the slot after lane ARRAY_HEIGHT-1 empties.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    drain_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in) state_d = STREAM;
      end
      STREAM: begin
        if (!valid_in) begin
          drain_cnt_d = CNT_W'(ARRAY_HEIGHT - 1);
          if (ARRAY_HEIGHT == 1) begin
            state_d    = IDLE;
            drain_done = en;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (valid_in) begin
          state_d     = STREAM;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q - CNT_W'(1);
          if (drain_cnt_q == CNT_W'(1)) begin
            state_d    = IDLE;
            drain_done = en;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        drain_cnt_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ifmap_in_skew_fifo.sv
// Directed bench for ifmap_in_skew_fifo at IFMAP_WIDTH=16, ARRAY_HEIGHT=4.
module tb_ifmap_in_skew_fifo;
  import systolic_pkg::*;

  logic              clk;
  logic              rst;
  logic              en;
  logic              valid_in;
  logic [3:0][15:0]  d_in_r;
  logic [3:0][15:0]  d_out_w;
  logic [3:0]        valid_out_w;
  logic              busy;
  logic              drain_done;

  int total = 0;
  int bad   = 0;

  ifmap_in_skew_fifo #(
    .IFMAP_WIDTH  (16),
    .ARRAY_HEIGHT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .valid_in    (valid_in),
    .d_in_r      (d_in_r),
    .d_out_w     (d_out_w),
    .valid_out_w (valid_out_w),
    .busy        (busy),
    .drain_done  (drain_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic e, input logic v,
                       input logic [15:0] l3, input logic [15:0] l2,
                       input logic [15:0] l1, input logic [15:0] l0);
    en       = e;
    valid_in = v;
    d_in_r   = {l3, l2, l1, l0};
  endtask

  // Check full cycle: valid vector, data, busy, drain_done; then advance one clock.
  task automatic cyc(input string tag, input logic [3:0] exp_v, input logic [63:0] exp_d,
                     input logic exp_busy, input logic exp_dd);
    #2;
    chk({tag, ".valid"}, 64'(valid_out_w), 64'(exp_v));
    chk({tag, ".data"},  64'(d_out_w),     exp_d);
    chk({tag, ".busy"},  64'(busy),        64'(exp_busy));
    chk({tag, ".done"},  64'(drain_done),  64'(exp_dd));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b1, 16'h0, 16'h0, 16'h0, 16'h1234);
    #2;
    chk("rst.lane0_follows", 64'(valid_out_w), 64'h1);
    chk("rst.lane0_data",    64'(d_out_w),     64'h0000_0000_0000_1234);
    chk("rst.busy_vin",      64'(busy),        64'h1);
    chk("rst.done",          64'(drain_done),  64'h0);
    valid_in = 1'b0;
    #1;
    chk("rst.valid_idle", 64'(valid_out_w), 64'h0);
    chk("rst.data_idle",  64'(d_out_w),     64'h0);
    chk("rst.busy_idle",  64'(busy),        64'h0);
    chk("rst.state",      64'(dut.state_q), 64'(IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Skew timing and drain pulse
    drive(1, 1, 16'd1, 16'd1, 16'd1, 16'd1); cyc("skew.c0", 4'b0001, 64'h0000_0000_0000_0001, 1, 0);
    drive(1, 1, 16'd2, 16'd2, 16'd2, 16'd2); cyc("skew.c1", 4'b0011, 64'h0000_0000_0001_0002, 1, 0);
    drive(1, 1, 16'd3, 16'd3, 16'd3, 16'd3); cyc("skew.c2", 4'b0111, 64'h0000_0001_0002_0003, 1, 0);
    drive(1, 1, 16'd4, 16'd4, 16'd4, 16'd4); cyc("skew.c3", 4'b1111, 64'h0001_0002_0003_0004, 1, 0);
    drive(1, 0, 16'd0, 16'd0, 16'd0, 16'd0); cyc("skew.c4", 4'b1110, 64'h0002_0003_0004_0000, 1, 0);
    cyc("skew.c5", 4'b1100, 64'h0003_0004_0000_0000, 1, 0);
    cyc("skew.c6", 4'b1000, 64'h0004_0000_0000_0000, 1, 0);
    cyc("skew.c7", 4'b0000, 64'h0, 0, 1);
    cyc("skew.c8", 4'b0000, 64'h0, 0, 0);

    // Stall in cycle 2, vector 3 re-presented in cycle 3
    drive(1, 1, 16'd1, 16'd1, 16'd1, 16'd1); cyc("stall.c0", 4'b0001, 64'h0000_0000_0000_0001, 1, 0);
    drive(1, 1, 16'd2, 16'd2, 16'd2, 16'd2); cyc("stall.c1", 4'b0011, 64'h0000_0000_0001_0002, 1, 0);
    drive(0, 1, 16'd3, 16'd3, 16'd3, 16'd3); cyc("stall.c2", 4'b0000, 64'h0, 1, 0);
    drive(1, 1, 16'd3, 16'd3, 16'd3, 16'd3); cyc("stall.c3", 4'b0111, 64'h0000_0001_0002_0003, 1, 0);
    drive(1, 1, 16'd4, 16'd4, 16'd4, 16'd4); cyc("stall.c4", 4'b1111, 64'h0001_0002_0003_0004, 1, 0);
    drive(1, 0, 16'd0, 16'd0, 16'd0, 16'd0); cyc("stall.c5", 4'b1110, 64'h0002_0003_0004_0000, 1, 0);
    cyc("stall.c6", 4'b1100, 64'h0003_0004_0000_0000, 1, 0);
    cyc("stall.c7", 4'b1000, 64'h0004_0000_0000_0000, 1, 0);
    cyc("stall.c8", 4'b0000, 64'h0, 0, 1);
    cyc("stall.c9", 4'b0000, 64'h0, 0, 0);

    // Bubble and restart: 5, gap (garbage data must not leak), 6
    drive(1, 1, 16'd5, 16'd5, 16'd5, 16'd5);         cyc("bub.c0", 4'b0001, 64'h0000_0000_0000_0005, 1, 0);
    drive(1, 0, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD); cyc("bub.c1", 4'b0010, 64'h0000_0000_0005_0000, 1, 0);
    drive(1, 1, 16'd6, 16'd6, 16'd6, 16'd6);         cyc("bub.c2", 4'b0101, 64'h0000_0005_0000_0006, 1, 0);
    drive(1, 0, 16'd0, 16'd0, 16'd0, 16'd0);         cyc("bub.c3", 4'b1010, 64'h0005_0000_0006_0000, 1, 0);
    cyc("bub.c4", 4'b0100, 64'h0000_0006_0000_0000, 1, 0);
    cyc("bub.c5", 4'b1000, 64'h0006_0000_0000_0000, 1, 0);
    cyc("bub.c6", 4'b0000, 64'h0, 0, 1);

    // Signed extremes pass through bit-exact
    drive(1, 1, 16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF); cyc("sgn.c0", 4'b0001, 64'h0000_0000_0000_FFFF, 1, 0);
    drive(1, 0, 16'd0, 16'd0, 16'd0, 16'd0);             cyc("sgn.c1", 4'b0010, 64'h0000_0000_8000_0000, 1, 0);
    cyc("sgn.c2", 4'b0100, 64'h0000_7FFF_0000_0000, 1, 0);
    cyc("sgn.c3", 4'b1000, 64'h0, 1, 0);
    // en low when the pulse is due: pulse moves to the next enabled cycle
    drive(0, 0, 16'd0, 16'd0, 16'd0, 16'd0); cyc("sgn.c4_stall", 4'b0000, 64'h0, 0, 0);
    drive(1, 0, 16'd0, 16'd0, 16'd0, 16'd0); cyc("sgn.c5", 4'b0000, 64'h0, 0, 1);
    cyc("sgn.c6", 4'b0000, 64'h0, 0, 0);

    // Async reset mid-stream, asserted and released between clock edges
    drive(1, 1, 16'd7, 16'd7, 16'd7, 16'd7); cyc("ar.c0", 4'b0001, 64'h0000_0000_0000_0007, 1, 0);
    drive(1, 1, 16'd8, 16'd8, 16'd8, 16'd8); cyc("ar.c1", 4'b0011, 64'h0000_0000_0007_0008, 1, 0);
    drive(1, 1, 16'd9, 16'd9, 16'd9, 16'd9);
    #2;
    chk("ar.pre_valid", 64'(valid_out_w), 64'h7);
    valid_in = 1'b0;
    rst      = 1'b1;
    #1;
    chk("ar.valid", 64'(valid_out_w), 64'h0);
    chk("ar.data",  64'(d_out_w),     64'h0);
    chk("ar.busy",  64'(busy),        64'h0);
    chk("ar.done",  64'(drain_done),  64'h0);
    chk("ar.state", 64'(dut.state_q), 64'(IDLE));
    #4;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      cyc($sformatf("ar.post%0d", k), 4'b0000, 64'h0, 0, 0);
    end
    chk("ar.state_end", 64'(dut.state_q), 64'(IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
